// File: rtl/temporizador_segundos_pkg.sv
// Shared timer definitions: FSM encodings, default range and BCD helpers.
// Also imported by the VGA display modules that render sec_bcd.
package temporizador_segundos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } estado_t;

  localparam int MAX_SEC_DEF = 99;
  localparam int BCD_W       = 4;

  // Two-digit BCD decrement; units wrap 0 -> 9 and borrow from tens.
  function automatic logic [2*BCD_W-1:0] bcd_dec(input logic [2*BCD_W-1:0] v);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
    tens  = v[2*BCD_W-1:BCD_W];
    units = v[BCD_W-1:0];
    if (units == '0) begin
      return {tens - BCD_W'(1), BCD_W'(9)};
    end
    return {tens, units - BCD_W'(1)};
  endfunction

endpackage

// File: rtl/temporizador_segundos_sincronizador_borda.sv
// Synchronises an asynchronous level and emits a one-clk pulse on its rising edge.
// Pulse appears SYNC_STAGES clk edges after the first edge that samples d high; no backpressure.
module sincronizador_borda #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist_q <= sync_out;
      pulse  <= sync_out & ~hist_q;
    end
  end

endmodule

// File: rtl/temporizador_segundos.sv
// Seconds countdown timer in BCD, driven by a divided square wave on tick_in.
// tick_out and the count update land SYNC_STAGES+1 edges after tick_in is sampled high; no backpressure.
module temporizador_segundos
  import temporizador_segundos_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_SEC     = MAX_SEC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [6:0] preset,
  output logic       tick_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] sec_bcd
);

  estado_t    state;
  logic       tick_pulse;
  logic [6:0] preset_sat;
  logic [7:0] preset_bcd;

  sincronizador_borda #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sincronizador_borda (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (tick_in),
    .pulse(tick_pulse)
  );

  // Presets above the display range saturate rather than wrap.
  always_comb begin
    preset_sat = (preset > 7'(MAX_SEC)) ? 7'(MAX_SEC) : preset;
    preset_bcd = {BCD_W'(preset_sat / 7'd10), BCD_W'(preset_sat % 7'd10)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sec_bcd  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      tick_out <= 1'b0;
    end else begin
      tick_out <= tick_pulse;
      done     <= 1'b0;
      if (clear) begin
        state   <= ST_IDLE;
        sec_bcd <= 8'h00;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              if (preset != 7'd0) begin
                state   <= ST_RUN;
                sec_bcd <= preset_bcd;
                busy    <= 1'b1;
              end else begin
                state   <= ST_DONE;
                sec_bcd <= 8'h00;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            // pause is checked first so a coincident tick is dropped
            if (pause) begin
              state <= ST_PAUSED;
            end else if (tick_pulse) begin
              if (sec_bcd == 8'h01) begin
                state   <= ST_DONE;
                sec_bcd <= 8'h00;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                sec_bcd <= bcd_dec(sec_bcd);
              end
            end
          end
          ST_PAUSED: begin
            if (!pause) begin
              state <= ST_RUN;
            end
          end
          default: begin
            state   <= ST_IDLE;
            sec_bcd <= 8'h00;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_temporizador_segundos.sv
// Bench for temporizador_segundos: directed vector table, corner sequences and
// randomized traffic, all against an integer-seconds reference model.
module tb_temporizador_segundos;

  localparam int S       = 2;
  localparam int MAXS    = 99;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_in;
  logic       start;
  logic       pause;
  logic       clear;
  logic [6:0] preset;
  logic       tick_out;
  logic       busy;
  logic       done;
  logic [7:0] sec_bcd;

  temporizador_segundos #(
    .SYNC_STAGES(S),
    .MAX_SEC    (MAXS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_in (tick_in),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .preset  (preset),
    .tick_out(tick_out),
    .busy    (busy),
    .done    (done),
    .sec_bcd (sec_bcd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt;
  int tick_cnt;

  // Reference model: remaining seconds as a plain integer plus a history of
  // tick_in samples; a tick is seen S+1 edges after the first high sample.
  int m_state;
  int m_rem;
  bit m_tick;
  bit m_done;
  bit samp[0:S+2];

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_rem   = 0;
    m_tick  = 1'b0;
    m_done  = 1'b0;
    for (int j = 0; j <= S + 2; j++) samp[j] = 1'b0;
  endtask

  task automatic model_step();
    bit t;
    for (int j = S + 2; j > 0; j--) samp[j] = samp[j-1];
    samp[0] = tick_in;
    t = samp[S+1] && !samp[S+2];
    m_tick = t;
    m_done = 1'b0;
    if (clear) begin
      m_state = M_IDLE;
      m_rem   = 0;
    end else if (m_state == M_IDLE || m_state == M_DONE) begin
      if (start) begin
        if (preset == 0) begin
          m_state = M_DONE;
          m_rem   = 0;
          m_done  = 1'b1;
        end else begin
          m_rem   = (int'(preset) > MAXS) ? MAXS : int'(preset);
          m_state = M_RUN;
        end
      end
    end else if (m_state == M_RUN) begin
      if (pause) begin
        m_state = M_PAUSE;
      end else if (t) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_state = M_DONE;
          m_done  = 1'b1;
        end
      end
    end else if (!pause) begin
      m_state = M_RUN;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    logic [10:0] act;
    logic [10:0] exp;
    bit          exp_busy;
    exp_busy = (m_state == M_RUN) || (m_state == M_PAUSE);
    act = {tick_out, busy, done, sec_bcd};
    exp = {m_tick, exp_busy, m_done, to_bcd(m_rem)};
    chk("model {tick_out,busy,done,sec_bcd}", 32'(act), 32'(exp));
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    if (done) done_cnt++;
    if (tick_out) tick_cnt++;
    check_model();
  endtask

  task automatic tick_once();
    tick_in = 1'b1;
    repeat (4) cyc();
    tick_in = 1'b0;
    repeat (4) cyc();
  endtask

  typedef struct {
    bit         st;
    bit         pa;
    bit         cl;
    logic [6:0] pre;
    bit         tin;
    int         n;
    logic [7:0] exp_sec;
    bit         exp_busy;
    int         exp_done;
  } vec_t;

  vec_t tbl[$];
  int   first_at;

  initial begin
    tbl.push_back('{1, 0, 0, 7'd3, 0, 1, 8'h03, 1, 0});
    tbl.push_back('{0, 0, 0, 7'd0, 1, 4, 8'h02, 1, 0});
    tbl.push_back('{0, 0, 0, 7'd0, 0, 4, 8'h02, 1, 0});
    tbl.push_back('{0, 0, 0, 7'd0, 1, 4, 8'h01, 1, 0});
    tbl.push_back('{0, 0, 0, 7'd0, 0, 4, 8'h01, 1, 0});
    tbl.push_back('{0, 0, 0, 7'd0, 1, 4, 8'h00, 0, 1});
    tbl.push_back('{0, 0, 0, 7'd0, 0, 4, 8'h00, 0, 0});
    tbl.push_back('{1, 0, 0, 7'd0, 0, 1, 8'h00, 0, 1});
    tbl.push_back('{0, 0, 0, 7'd0, 0, 2, 8'h00, 0, 0});
    tbl.push_back('{1, 0, 0, 7'd2, 0, 1, 8'h02, 1, 0});
    tbl.push_back('{0, 0, 0, 7'd0, 1, 4, 8'h01, 1, 0});
    tbl.push_back('{0, 0, 0, 7'd0, 0, 4, 8'h01, 1, 0});
    tbl.push_back('{0, 0, 0, 7'd0, 1, 4, 8'h00, 0, 1});
    tbl.push_back('{0, 0, 0, 7'd0, 0, 4, 8'h00, 0, 0});

    rst_n = 1'b0; tick_in = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; preset = 7'd0;
    done_cnt = 0; tick_cnt = 0;
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    chk("reset sec_bcd", 32'(sec_bcd), 32'h00);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset tick_out", 32'(tick_out), 32'd0);

    // Rising edge: pulse on the 4th edge only; falling edge: nothing.
    repeat (2) cyc();
    tick_in = 1'b1;
    tick_cnt = 0; first_at = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (tick_out && first_at == 0) first_at = i;
    end
    chk("tick_out latency", 32'(first_at), 32'd4);
    chk("tick_out width", 32'(tick_cnt), 32'd1);
    tick_in = 1'b0;
    tick_cnt = 0;
    repeat (6) cyc();
    chk("no pulse on falling edge", 32'(tick_cnt), 32'd0);

    foreach (tbl[k]) begin
      start = tbl[k].st; pause = tbl[k].pa; clear = tbl[k].cl;
      preset = tbl[k].pre; tick_in = tbl[k].tin;
      done_cnt = 0;
      repeat (tbl[k].n) cyc();
      chk($sformatf("vec%0d sec_bcd", k), 32'(sec_bcd), 32'(tbl[k].exp_sec));
      chk($sformatf("vec%0d busy", k), 32'(busy), 32'(tbl[k].exp_busy));
      chk($sformatf("vec%0d done count", k), 32'(done_cnt), 32'(tbl[k].exp_done));
    end
    start = 1'b0; tick_in = 1'b0;

    // Saturated preset and the tens borrow.
    preset = 7'd120; start = 1'b1; cyc(); start = 1'b0;
    chk("sat preset", 32'(sec_bcd), 32'h99);
    for (int i = 1; i <= 10; i++) begin
      tick_once();
      if (i == 9) chk("pass 90", 32'(sec_bcd), 32'h90);
    end
    chk("after 10 ticks", 32'(sec_bcd), 32'h89);
    clear = 1'b1; cyc(); clear = 1'b0;

    // Pause holds through ticks.
    done_cnt = 0;
    preset = 7'd5; start = 1'b1; cyc(); start = 1'b0;
    tick_once(); tick_once();
    chk("before pause", 32'(sec_bcd), 32'h03);
    pause = 1'b1;
    repeat (4) tick_once();
    chk("paused hold", 32'(sec_bcd), 32'h03);
    chk("paused busy", 32'(busy), 32'd1);
    pause = 1'b0; cyc();
    repeat (3) tick_once();
    chk("after resume", 32'(sec_bcd), 32'h00);
    chk("pause done once", 32'(done_cnt), 32'd1);

    // clear beats start mid-count.
    preset = 7'd50; start = 1'b1; cyc(); start = 1'b0;
    tick_once(); tick_once();
    chk("mid 48", 32'(sec_bcd), 32'h48);
    clear = 1'b1; start = 1'b1; cyc();
    chk("clear+start sec", 32'(sec_bcd), 32'h00);
    chk("clear+start busy", 32'(busy), 32'd0);
    clear = 1'b0; start = 1'b0; cyc();

    // Asynchronous reset mid-count, checked before the next edge.
    preset = 7'd30; start = 1'b1; cyc(); start = 1'b0;
    tick_once();
    chk("mid 29", 32'(sec_bcd), 32'h29);
    tick_in = 1'b1; cyc(); cyc(); cyc();
    #2; rst_n = 1'b0; model_reset(); #1;
    chk("async rst outputs", 32'({tick_out, busy, done, sec_bcd}), 32'd0);
    tick_in = 1'b1;
    repeat (2) cyc();

    // tick_in already high at release yields exactly one pulse.
    rst_n = 1'b1;
    tick_cnt = 0; first_at = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (tick_out && first_at == 0) first_at = i;
    end
    chk("release tick latency", 32'(first_at), 32'd4);
    chk("release tick count", 32'(tick_cnt), 32'd1);
    tick_in = 1'b0;
    repeat (4) cyc();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
      start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      clear = ($urandom_range(0, 59) == 0);
      preset = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 6));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
